mod_txt_fetch_arb: RTL and testbench
====================================

MOD_TXT_FETCH_ARB -- requirements
Module: mod_txt_fetch_arb

Interface
REQ-001 SHALL have parameter READ_LAT, default 3: cycles from memCellIx valid to memCellData valid.
REQ-002 SHALL have parameter STARVE_MAX, default 8: CPU wait cycles before the CPU overrides display priority.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles the CPU may stay granted without memOK==01.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have these display ports:
- dispReq  in  1  display cell fetch request.
- dispCellIx  in  14  cell index to fetch.
- dispAck  out  1  one-cycle pulse; dispCellData valid.
- dispCellData  out  256  fetched cell.
REQ-006 SHALL have these CPU ports:
- cpuAddr  in  32  bus address.
- cpuInData  in  64  write data.
- cpuOE, cpuWR, cpuQW  in  1 each  read strobe, write strobe, 64-bit access.
- cpuOutData  out  64  read data.
- cpuOK  out  2  00 idle, 01 ready, 10 hold, 11 error.
REQ-007 SHALL have these memory-side ports:
- memCellIx  out  14  cell index.
- memCellData  in  256  cell data.
- memAddr  out  32  address.
- memInData  out  64  write data.
- memOE, memWR, memQW  out  1 each  strobes.
- memOutData  in  64  read data.
- memOK  in  2  memory status, same encoding as cpuOK.

Function
REQ-008 SHALL implement states IDLE, DISP_WAIT, CPU_RUN and CPU_DONE.
REQ-009 IDLE: dispReq SHALL move to DISP_WAIT, unless (cpuOE|cpuWR) is set and the starve count is >= STARVE_MAX, which SHALL move to CPU_RUN.
REQ-010 IDLE: with (cpuOE|cpuWR) set and dispReq low, SHALL move to CPU_RUN.
REQ-011 IDLE with both requests and starve count < STARVE_MAX: display SHALL win.
REQ-012 On DISP_WAIT entry SHALL latch dispCellIx, drive it on memCellIx, and hold memCellIx stable for READ_LAT cycles.
REQ-013 After the READ_LAT cycles SHALL capture memCellData into dispCellData, pulse dispAck for 1 cycle, and return to IDLE. This SHALL happen even if dispReq drops during the fetch.
REQ-014 Display fetch latency SHALL be READ_LAT+1 cycles from grant to dispAck.
REQ-015 The starve counter SHALL increment each cycle (cpuOE|cpuWR) is high while the CPU is not granted, SHALL saturate at STARVE_MAX, and SHALL clear on CPU_RUN entry.
REQ-016 While the CPU is not granted: cpuOK SHALL be 10 when (cpuOE|cpuWR) is high, else 00; memOE and memWR SHALL be 0.
REQ-017 CPU_RUN: memAddr, memInData, memOE, memWR and memQW SHALL follow the CPU inputs combinationally.
REQ-018 CPU_RUN: memCellIx SHALL equal cpuAddr[18:5].
REQ-019 CPU_RUN: cpuOK SHALL be 10 until memOK==01.
REQ-020 CPU_RUN, on memOK==01: SHALL latch memOutData into cpuOutData and go to CPU_DONE.
REQ-021 CPU_RUN, on memOK==11 or TIMEOUT cycles elapsed: SHALL go to CPU_DONE with the error flag set and cpuOutData=0.
REQ-022 CPU_DONE: cpuOK SHALL be 01, or 11 if the error flag is set; memOE and memWR SHALL be 0.
REQ-023 CPU_DONE: SHALL return to IDLE when cpuOE and cpuWR are both low.
REQ-024 Outside DISP_WAIT and CPU_RUN, memCellIx SHALL hold its last value.
REQ-025 The latency and timeout counters SHALL be ceil(log2(max+1)) bits and SHALL never wrap.
REQ-026 A CPU request dropping during CPU_RUN SHALL abort to IDLE next cycle with no cpuOK 01 pulse.

Reset
REQ-027 While reset is high: state SHALL be IDLE; all counters and the error flag SHALL be 0.
REQ-028 While reset is high: dispAck SHALL be 0, and dispCellData and cpuOutData SHALL be 0.
REQ-029 While reset is high: cpuOK SHALL be 00; memOE, memWR and memQW SHALL be 0; memCellIx, memAddr and memInData SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abandon the transaction immediately; no dispAck and no cpuOK 01 SHALL follow.

Structure
REQ-031 Package mod_txt_pkg SHALL hold the state enumeration, the OK codes (OK_IDLE=00, OK_READY=01, OK_HOLD=10, OK_ERR=11) and the parameter defaults.
REQ-032 The saturating starve/timeout counter SHALL be one sub-module, mod_txt_sat_ctr, instantiated twice; all other logic SHALL be flat.

Verification
REQ-033 dispReq=1, dispCellIx=0x0123, memCellData=pattern P -> memCellIx=0x0123 for 3 cycles; dispAck pulses at cycle 4 with dispCellData=P.
REQ-034 cpuOE=1, cpuAddr=0x000A0008, idle display, memOK=01 after 2 cycles with memOutData=0x1122334455667788 -> cpuOK goes 10,10,01; cpuOutData matches; IDLE after cpuOE drops.
REQ-035 dispReq held high continuously with cpuWR=1 -> the CPU is granted once the starve count reaches 8; the display resumes after CPU_DONE.
REQ-036 cpuOE=1 with memOK held at 10 -> after 64 cycles cpuOK=11 and cpuOutData=0.
REQ-037 reset asserted during DISP_WAIT cycle 2 -> no dispAck, all outputs 0 next cycle, and a fetch issued after reset completes normally.
REQ-038 dispReq and cpuOE rise in the same cycle with starve count 0 -> display granted first; the CPU completes immediately after.

Source files
------------

// File: rtl/mod_txt_pkg.sv
// mod_txt_pkg: shared types and constants for the text-cell fetch arbiter.
//   arbState_t   - arbiter FSM state encoding
//   OK_*         - bus status codes used on cpuOK and memOK
//   *_DEF        - default values for the arbiter parameters
package mod_txt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISP_WAIT = 2'd1,
    CPU_RUN   = 2'd2,
    CPU_DONE  = 2'd3
  } arbState_t;

  localparam logic [1:0] OK_IDLE  = 2'b00;
  localparam logic [1:0] OK_READY = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_ERR   = 2'b11;

  localparam int READ_LAT_DEF   = 3;
  localparam int STARVE_MAX_DEF = 8;
  localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/mod_txt_sat_ctr.sv
// mod_txt_sat_ctr: up-counter that saturates at MAX and never wraps.
//   clock  in   sole clock
//   reset  in   synchronous, active-high reset (count -> 0)
//   clr    in   clear to 0 (wins over inc)
//   inc    in   count up by one, stopping at MAX
//   count  out  current count, WIDTH bits
module mod_txt_sat_ctr
  import mod_txt_pkg::*;
#(
  parameter int MAX   = STARVE_MAX_DEF,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < MAX_C)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_txt_fetch_arb.sv
// mod_txt_fetch_arb: arbitrates one cell memory between display cell fetches
// and CPU bus accesses. The display normally has priority; a CPU kept waiting
// STARVE_MAX cycles overrides it.
//   clock, reset                    sole clock, synchronous active-high reset
//   dispReq/dispCellIx              display fetch request and cell index
//   dispAck/dispCellData            one-cycle completion pulse and fetched cell
//   cpuAddr/cpuInData/cpuOE/cpuWR/cpuQW  CPU bus request
//   cpuOutData/cpuOK                CPU read data and status (00/01/10/11)
//   memCellIx/memCellData           cell-port index out, cell data in
//   memAddr/memInData/memOE/memWR/memQW  bus-port request to memory
//   memOutData/memOK                bus-port read data and status
//
// state     | meaning
// IDLE      | nothing granted, choose next owner
// DISP_WAIT | display granted, cell index held for READ_LAT cycles
// CPU_RUN   | CPU granted, bus passed through to memory
// CPU_DONE  | CPU access finished, status shown until strobes drop
module mod_txt_fetch_arb
  import mod_txt_pkg::*;
#(
  parameter int READ_LAT   = READ_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dispReq,
  input  logic [13:0]  dispCellIx,
  output logic         dispAck,
  output logic [255:0] dispCellData,
  input  logic [31:0]  cpuAddr,
  input  logic [63:0]  cpuInData,
  input  logic         cpuOE,
  input  logic         cpuWR,
  input  logic         cpuQW,
  output logic [63:0]  cpuOutData,
  output logic [1:0]   cpuOK,
  output logic [13:0]  memCellIx,
  input  logic [255:0] memCellData,
  output logic [31:0]  memAddr,
  output logic [63:0]  memInData,
  output logic         memOE,
  output logic         memWR,
  output logic         memQW,
  input  logic [63:0]  memOutData,
  input  logic [1:0]   memOK
);

  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arbState_t        state;
  logic [LAT_W-1:0] latCnt;
  logic [STV_W-1:0] starveCnt;
  logic [TMO_W-1:0] tmoCnt;
  logic [13:0]      cellIxReg;
  logic             dispAckReg;
  logic [255:0]     dispDataReg;
  logic [63:0]      cpuDataReg;
  logic             errFlag;

  logic cpuReq, cpuGranted, cpuStarved, runEntry, tmoHit;

  assign cpuReq     = cpuOE | cpuWR;
  assign cpuGranted = (state == CPU_RUN) || (state == CPU_DONE);
  assign cpuStarved = starveCnt >= STV_LIM;
  assign runEntry   = (state == IDLE) && cpuReq && (!dispReq || cpuStarved);
  // tmoCnt counts completed CPU_RUN cycles, so this is the TIMEOUT-th one
  assign tmoHit     = tmoCnt >= TMO_LAST;

  mod_txt_sat_ctr #(.MAX(STARVE_MAX), .WIDTH(STV_W)) uStarveCtr (
    .clock (clock),
    .reset (reset),
    .clr   (runEntry),
    .inc   (cpuReq && !cpuGranted),
    .count (starveCnt)
  );

  mod_txt_sat_ctr #(.MAX(TIMEOUT), .WIDTH(TMO_W)) uTimeoutCtr (
    .clock (clock),
    .reset (reset),
    .clr   (runEntry),
    .inc   (state == CPU_RUN),
    .count (tmoCnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      latCnt      <= '0;
      cellIxReg   <= '0;
      dispAckReg  <= 1'b0;
      dispDataReg <= '0;
      cpuDataReg  <= '0;
      errFlag     <= 1'b0;
    end else begin
      dispAckReg <= 1'b0;
      case (state)
        IDLE: begin
          if (dispReq && !(cpuReq && cpuStarved)) begin
            state     <= DISP_WAIT;
            cellIxReg <= dispCellIx;
            latCnt    <= LAT_LOAD;
          end else if (cpuReq) begin
            state   <= CPU_RUN;
            errFlag <= 1'b0;
          end
        end
        DISP_WAIT: begin
          // completes regardless of dispReq once started
          if (latCnt == '0) begin
            dispDataReg <= memCellData;
            dispAckReg  <= 1'b1;
            state       <= IDLE;
          end else begin
            latCnt <= latCnt - 1'b1;
          end
        end
        CPU_RUN: begin
          // tracks the index driven combinationally so it holds afterwards
          cellIxReg <= cpuAddr[18:5];
          if (!cpuReq) begin
            state <= IDLE;
          end else if (memOK == OK_READY) begin
            cpuDataReg <= memOutData;
            errFlag    <= 1'b0;
            state      <= CPU_DONE;
          end else if ((memOK == OK_ERR) || tmoHit) begin
            cpuDataReg <= '0;
            errFlag    <= 1'b1;
            state      <= CPU_DONE;
          end
        end
        CPU_DONE: begin
          if (!cpuReq) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced to 0 while reset is high so a transaction in flight
  // is dropped in the very cycle reset rises.
  always_comb begin
    memAddr   = '0;
    memInData = '0;
    memOE     = 1'b0;
    memWR     = 1'b0;
    memQW     = 1'b0;
    memCellIx = cellIxReg;
    cpuOK     = cpuReq ? OK_HOLD : OK_IDLE;
    case (state)
      CPU_RUN: begin
        memAddr   = cpuAddr;
        memInData = cpuInData;
        memOE     = cpuOE;
        memWR     = cpuWR;
        memQW     = cpuQW;
        memCellIx = cpuAddr[18:5];
        cpuOK     = OK_HOLD;
      end
      CPU_DONE: cpuOK = errFlag ? OK_ERR : OK_READY;
      default: ;
    endcase
    if (reset) begin
      memAddr   = '0;
      memInData = '0;
      memOE     = 1'b0;
      memWR     = 1'b0;
      memQW     = 1'b0;
      memCellIx = '0;
      cpuOK     = OK_IDLE;
    end
  end

  assign dispAck      = dispAckReg & ~reset;
  assign dispCellData = reset ? '0 : dispDataReg;
  assign cpuOutData   = reset ? '0 : cpuDataReg;

endmodule

// File: tb/tb_mod_txt_fetch_arb.sv
// tb_mod_txt_fetch_arb: directed bench for mod_txt_fetch_arb with default
// parameters (READ_LAT=3, STARVE_MAX=8, TIMEOUT=64).
module tb_mod_txt_fetch_arb;
  import mod_txt_pkg::*;

  localparam logic [255:0] PAT_P = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] PAT_Q = {8{32'h5A5A_C3C3}};

  logic         clock = 1'b0;
  logic         reset;
  logic         dispReq;
  logic [13:0]  dispCellIx;
  logic         dispAck;
  logic [255:0] dispCellData;
  logic [31:0]  cpuAddr;
  logic [63:0]  cpuInData;
  logic         cpuOE, cpuWR, cpuQW;
  logic [63:0]  cpuOutData;
  logic [1:0]   cpuOK;
  logic [13:0]  memCellIx;
  logic [255:0] memCellData;
  logic [31:0]  memAddr;
  logic [63:0]  memInData;
  logic         memOE, memWR, memQW;
  logic [63:0]  memOutData;
  logic [1:0]   memOK;

  int nVec = 0;
  int nErr = 0;
  int acks, grantAt, ackAt;

  mod_txt_fetch_arb dut (
    .clock(clock), .reset(reset),
    .dispReq(dispReq), .dispCellIx(dispCellIx), .dispAck(dispAck), .dispCellData(dispCellData),
    .cpuAddr(cpuAddr), .cpuInData(cpuInData), .cpuOE(cpuOE), .cpuWR(cpuWR), .cpuQW(cpuQW),
    .cpuOutData(cpuOutData), .cpuOK(cpuOK),
    .memCellIx(memCellIx), .memCellData(memCellData), .memAddr(memAddr), .memInData(memInData),
    .memOE(memOE), .memWR(memWR), .memQW(memQW), .memOutData(memOutData), .memOK(memOK)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset with live CPU strobes: everything must still read 0
    reset = 1'b1; dispReq = 1'b0; dispCellIx = 14'h0;
    cpuAddr = 32'hFFFF_FFFF; cpuInData = 64'hFFFF; cpuOE = 1'b1; cpuWR = 1'b1; cpuQW = 1'b1;
    memCellData = PAT_P; memOutData = 64'h0; memOK = OK_IDLE;
    tick(); tick();
    checkVal("rst_cpuOK", cpuOK, OK_IDLE);
    checkVal("rst_memStrobes", {memOE, memWR, memQW}, 3'b000);
    checkVal("rst_memAddr", memAddr, 32'h0);
    checkVal("rst_memInData", memInData, 64'h0);
    checkVal("rst_memCellIx", memCellIx, 14'h0);
    checkVal("rst_dispAck", dispAck, 1'b0);
    checkVal("rst_dispCellData", dispCellData, 256'h0);
    checkVal("rst_cpuOutData", cpuOutData, 64'h0);
    cpuOE = 1'b0; cpuWR = 1'b0; cpuQW = 1'b0; cpuAddr = 32'h0; cpuInData = 64'h0;
    tick();
    reset = 1'b0;
    tick();

    // display fetch, request dropped and index changed after the grant
    dispReq = 1'b1; dispCellIx = 14'h0123;
    tick();
    dispReq = 1'b0; dispCellIx = 14'h3FFF;
    for (int c = 1; c <= 3; c++) begin
      checkVal($sformatf("disp_ix_c%0d", c), memCellIx, 14'h0123);
      checkVal($sformatf("disp_noack_c%0d", c), dispAck, 1'b0);
      tick();
    end
    checkVal("disp_ack_c4", dispAck, 1'b1);
    checkVal("disp_data_c4", dispCellData, PAT_P);
    tick();
    checkVal("disp_ack_c5", dispAck, 1'b0);
    checkVal("disp_ix_hold", memCellIx, 14'h0123);

    // CPU read, memory ready in the second granted cycle
    cpuOE = 1'b1; cpuQW = 1'b1; cpuAddr = 32'h000A_0008; cpuInData = 64'hA5;
    memOK = OK_HOLD; memOutData = 64'h1122_3344_5566_7788;
    #1;
    checkVal("cpu_idle_hold", cpuOK, OK_HOLD);
    checkVal("cpu_idle_memOE", memOE, 1'b0);
    tick();
    checkVal("cpu_run1_ok", cpuOK, OK_HOLD);
    checkVal("cpu_run1_memOE", memOE, 1'b1);
    checkVal("cpu_run1_memQW", memQW, 1'b1);
    checkVal("cpu_run1_addr", memAddr, 32'h000A_0008);
    checkVal("cpu_run1_wdata", memInData, 64'hA5);
    checkVal("cpu_run1_cellix", memCellIx, 14'h1000);
    tick();
    checkVal("cpu_run2_ok", cpuOK, OK_HOLD);
    memOK = OK_READY;
    tick();
    checkVal("cpu_done_ok", cpuOK, OK_READY);
    checkVal("cpu_done_data", cpuOutData, 64'h1122_3344_5566_7788);
    checkVal("cpu_done_memOE", memOE, 1'b0);
    cpuOE = 1'b0; cpuQW = 1'b0; memOK = OK_IDLE;
    tick();
    checkVal("cpu_back_idle_ok", cpuOK, OK_IDLE);
    checkVal("cpu_cellix_hold", memCellIx, 14'h1000);

    // timeout: memory stuck at HOLD
    cpuOE = 1'b1; cpuAddr = 32'h0000_0100; memOK = OK_HOLD;
    tick();
    for (int k = 1; k < 64; k++) tick();
    checkVal("tmo_c64_ok", cpuOK, OK_HOLD);
    tick();
    checkVal("tmo_ok", cpuOK, OK_ERR);
    checkVal("tmo_data", cpuOutData, 64'h0);
    cpuOE = 1'b0; memOK = OK_IDLE;
    tick();

    // memory reports error
    cpuOE = 1'b1; memOK = OK_HOLD;
    tick();
    memOK = OK_ERR;
    tick();
    checkVal("memerr_ok", cpuOK, OK_ERR);
    cpuOE = 1'b0; memOK = OK_IDLE;
    tick();

    // CPU drops its strobe mid-access: abort, no READY pulse
    cpuWR = 1'b1; memOK = OK_HOLD;
    tick();
    checkVal("abort_memWR", memWR, 1'b1);
    cpuWR = 1'b0; memOK = OK_READY;
    #1;
    checkVal("abort_memWR_follow", memWR, 1'b0);
    tick();
    checkVal("abort_ok1", cpuOK, OK_IDLE);
    memOK = OK_IDLE;
    tick();
    checkVal("abort_ok2", cpuOK, OK_IDLE);

    // starvation: display requests continuously, CPU write waits
    dispReq = 1'b1; dispCellIx = 14'h0007; cpuWR = 1'b1; cpuAddr = 32'h0000_0040;
    memOK = OK_HOLD; memCellData = PAT_Q;
    acks = 0; grantAt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) checkVal("starve_hold_ok", cpuOK, OK_HOLD);
      if (dispAck) acks++;
      if (memWR) begin
        grantAt = i;
        break;
      end
    end
    checkVal("starve_acks", acks, 2);
    checkVal("starve_grant_cyc", grantAt, 9);
    memOK = OK_READY; memOutData = 64'h0BAD_F00D;
    tick();
    checkVal("starve_done_ok", cpuOK, OK_READY);
    cpuWR = 1'b0; memOK = OK_IDLE;
    ackAt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (dispAck) begin
        ackAt = i;
        break;
      end
    end
    checkVal("starve_disp_resume", ackAt, 5);
    dispReq = 1'b0;
    tick();

    // simultaneous requests with empty starve count: display first
    dispReq = 1'b1; cpuOE = 1'b1; dispCellIx = 14'h0ABC; memCellData = PAT_P;
    cpuAddr = 32'h0000_1FE0; memOK = OK_IDLE; memOutData = 64'hCAFE_F00D;
    tick();
    checkVal("both_disp_ix", memCellIx, 14'h0ABC);
    checkVal("both_disp_memOE", memOE, 1'b0);
    checkVal("both_disp_ok", cpuOK, OK_HOLD);
    dispReq = 1'b0;
    tick(); tick(); tick();
    checkVal("both_disp_ack", dispAck, 1'b1);
    tick();
    checkVal("both_cpu_memOE", memOE, 1'b1);
    checkVal("both_cpu_cellix", memCellIx, 14'h00FF);
    memOK = OK_READY;
    tick();
    checkVal("both_cpu_done", cpuOK, OK_READY);
    checkVal("both_cpu_data", cpuOutData, 64'hCAFE_F00D);
    cpuOE = 1'b0; memOK = OK_IDLE;
    tick();

    // reset during the second DISP_WAIT cycle
    dispReq = 1'b1; dispCellIx = 14'h0055; memCellData = PAT_Q;
    tick();
    dispReq = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkVal("rstmid_dispAck", dispAck, 1'b0);
    checkVal("rstmid_dispData", dispCellData, 256'h0);
    checkVal("rstmid_cellix", memCellIx, 14'h0);
    checkVal("rstmid_cpuData", cpuOutData, 64'h0);
    reset = 1'b0;
    acks = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (dispAck) acks++;
    end
    checkVal("rstmid_no_ack", acks, 0);
    dispReq = 1'b1; dispCellIx = 14'h2222; memCellData = PAT_P;
    ackAt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      dispReq = 1'b0;
      if (dispAck) begin
        ackAt = i;
        break;
      end
    end
    checkVal("rstmid_refetch_cyc", ackAt, 4);
    checkVal("rstmid_refetch_data", dispCellData, PAT_P);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
